// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and defaults for the MIPS IF stage (fetch state,
//           IF/ID bundle, reset/bubble constants, saturating increment).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int          c_AW        = 32;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [0:0] {
        REQ = 1'b0,
        BUF = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [c_AW-1:0] instr;
        logic [c_AW-1:0] pc4;
        logic            valid;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module  : fetch_skid_buf
// Brief   : One-entry {instr, pc4} holding register used while IF/ID stalls.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc4,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc4,
    output logic         o_valid
);

    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc4;
    logic         r_valid;

    // Clear wins over load so a flush in the capture cycle leaves it empty.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
// ============================================================================
// Module  : fetch_stage_ctrl
// Brief   : IF-stage controller: PC, imem req/ready handshake, skid buffer and
//           IF/ID register. Optional counters under FETCH_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int            AW        = c_AW,
    parameter logic [AW-1:0] RESET_PC  = c_RESET_PC,
    parameter logic [AW-1:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCWrite,
    input  logic          IF_ID_Write,
    input  logic          flush,
    input  logic [AW-1:0] branch_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [AW-1:0] imem_rdata,
    output logic [AW-1:0] instr_IF_ID,
    output logic [AW-1:0] pc4_IF_ID,
    output logic          valid_IF_ID,
    output logic          fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    localparam logic [AW-1:0] c_PC_STEP = AW'(4);

    fetch_state_t  r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt, w_pc4;
    logic          r_drop, w_drop_nxt;
    if_id_t        r_if_id, w_if_id_nxt;

    logic          w_flush_ok;
    logic          w_deliver;
    logic          w_bubble;
    logic          w_buf_load;
    logic          w_buf_clear;
    logic          w_buf_valid;
    logic [AW-1:0] w_buf_instr;
    logic [AW-1:0] w_buf_pc4;

    assign w_pc4      = r_pc + c_PC_STEP;
    assign w_flush_ok = flush && IF_ID_Write;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_if_id_nxt = r_if_id;
        w_deliver   = 1'b0;
        w_bubble    = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;

        if (w_flush_ok) begin
            w_pc_nxt    = branch_target;
            w_bubble    = 1'b1;
            w_buf_clear = 1'b1;
            w_state_nxt = REQ;
            // The request stays in flight at memory; its late word must be dropped.
            w_drop_nxt  = (r_state == REQ) && !imem_ready;
        end else begin
            unique case (r_state)
                REQ: begin
                    if (imem_ready && r_drop) begin
                        w_drop_nxt = 1'b0;
                        w_bubble   = IF_ID_Write;
                    end else if (imem_ready) begin
                        if (IF_ID_Write) begin
                            w_if_id_nxt = '{instr: imem_rdata, pc4: w_pc4, valid: 1'b1};
                            w_deliver   = 1'b1;
                            if (PCWrite) w_pc_nxt = w_pc4;
                        end else begin
                            w_buf_load  = 1'b1;
                            w_state_nxt = BUF;
                        end
                    end else begin
                        w_bubble = IF_ID_Write;
                    end
                end
                BUF: begin
                    if (IF_ID_Write) begin
                        w_if_id_nxt = '{instr: w_buf_instr, pc4: w_buf_pc4, valid: w_buf_valid};
                        w_deliver   = 1'b1;
                        w_buf_clear = 1'b1;
                        w_state_nxt = REQ;
                        if (PCWrite) w_pc_nxt = w_pc4;
                    end
                end
                default: w_state_nxt = REQ;
            endcase
        end

        if (w_bubble) begin
            w_if_id_nxt = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
            r_if_id <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_if_id <= w_if_id_nxt;
        end
    end

    fetch_skid_buf #(
        .W (AW)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .o_instr (w_buf_instr),
        .o_pc4   (w_buf_pc4),
        .o_valid (w_buf_valid)
    );

    assign imem_req    = (r_state == REQ) && !rst;
    assign imem_addr   = r_pc;
    assign instr_IF_ID = r_if_id.instr;
    assign pc4_IF_ID   = r_if_id.pc4;
    assign valid_IF_ID = r_if_id.valid;
    assign fetch_busy  = (r_state != BUF) && !w_deliver;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, !IF_ID_Write);
            r_bubble_cnt <= sat_inc(r_bubble_cnt, w_bubble);
            r_flush_cnt  <= sat_inc(r_flush_cnt, w_flush_ok);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- IF-stage controller and IF/ID pipeline register of the 5-stage MIPS core.
- Consumes PCWrite / IF_ID_Write from the load-use hazard detector, plus the ID-stage branch redirect.
- Owns the PC, drives a req/ready instruction-memory handshake, and buffers a fetched word while the pipeline is stalled.
- Delivers instr / PC+4 / valid to the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) placed in IF/ID.
- AW, 32, address/instruction width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous to clk, active-high.
- PCWrite  in  1  from hazard detector; 0 freezes the PC.
- IF_ID_Write  in  1  from hazard detector; 0 freezes the IF/ID register.
- flush  in  1  taken branch/jump resolved in ID.
- branch_target  in  AW  redirect address, valid with flush.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address; equals the PC.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  AW  fetched instruction.
- instr_IF_ID  out  AW  IF/ID instruction.
- pc4_IF_ID  out  AW  IF/ID PC+4.
- valid_IF_ID  out  1  IF/ID holds a real instruction.
- fetch_busy  out  1  state is not BUF and no word has been delivered this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc=RESET_PC, state=REQ.
  - instr_IF_ID=NOP_INSTR, pc4_IF_ID=0, valid_IF_ID=0.
  - imem_req=0 during the reset cycle; drop_pending=0; buffer cleared.
  - Reset mid-handshake abandons the outstanding request; memory must tolerate a dropped req.
- States: REQ (request outstanding), BUF (fetched word held, waiting for IF_ID_Write).
- REQ:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - imem_ready=1 with drop_pending=1: discard the word, clear drop_pending, stay in REQ and request the current pc.
  - imem_ready=1 and IF_ID_Write=1:
    - IF/ID <= {imem_rdata, pc+4, valid=1}.
    - If PCWrite=1, pc <= pc+4.
    - Stay in REQ.
  - imem_ready=1 and IF_ID_Write=0: capture the word into the skid buffer (sub-module), go to BUF, pc unchanged.
  - imem_ready=0 and IF_ID_Write=1: IF/ID <= bubble (NOP_INSTR, valid=0).
  - imem_ready=0 and IF_ID_Write=0: IF/ID holds.
- BUF:
  - imem_req=0.
  - IF_ID_Write=1: IF/ID <= buffer contents, valid=1. If PCWrite=1, pc <= pc+4. Go to REQ.
  - IF_ID_Write=0: IF/ID holds; stay in BUF.
- Flush (honoured only when IF_ID_Write=1):
  - pc <= branch_target.
  - IF/ID <= bubble.
  - Buffer discarded; state -> REQ.
  - If a request is outstanding without imem_ready this cycle, set drop_pending; the late word is discarded.
  - Flush overrides every normal-path update above.
- flush with IF_ID_Write=0: flush is ignored; the branch stays in ID and re-asserts flush next cycle.
- Priority: rst > (flush & IF_ID_Write) > stall > normal advance.
- PC arithmetic is modulo 2^AW; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency: a word returned with imem_ready appears on the IF/ID outputs the next cycle.
- imem_ready while imem_req=0 is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0], bubble_cnt[31:0], flush_cnt[31:0]; each is reset to 0 and saturates at all-ones.
  - stall_cnt: cycles with IF_ID_Write=0.
  - bubble_cnt: cycles in which a bubble is loaded into IF/ID.
  - flush_cnt: flushes honoured.
- Undefined: ports and logic absent; functional behaviour identical.

Decomposition:
- Shared package (pipeline_pkg):
  - fetch_state_t enum {REQ, BUF}.
  - NOP_INSTR and RESET_PC defaults.
  - IF/ID bundle typedef {instr, pc4, valid}.
- Sub-module: fetch_skid_buf, a one-entry {instr, pc4} holding register with load/clear/valid.

Test Plan:
- Reset, imem_ready=1 every cycle, no stalls -> imem_addr 0,4,8,C on consecutive cycles; instr_IF_ID follows one cycle later with valid=1.
- Word 32'h8C41_0004 returned at addr 8 while PCWrite=IF_ID_Write=0 for 3 cycles -> state BUF, imem_req=0, pc=8 held, IF/ID unchanged; on release IF/ID=8C41_0004, pc4=C, next imem_addr=C.
- flush=1 with branch_target=32'h0000_0040 while a request is outstanding, ready arriving 2 cycles later -> IF/ID bubble (valid=0), late word discarded, next accepted fetch address 40.
- flush=1 together with IF_ID_Write=0 -> no redirect, pc held; flush on the next cycle with IF_ID_Write=1 -> redirect occurs.
- RESET_PC=32'hFFFF_FFFC, one fetch -> next imem_addr=0 (wrap).
- rst asserted while in BUF -> next cycle pc=RESET_PC, valid_IF_ID=0, state REQ, buffer empty; counters are 0 when FETCH_PERF_CNT_EN is defined.
